sram_arbiter: RTL and testbench
===============================

# sram_arbiter

Shares the single external 16-bit asynchronous SRAM between three requesters: the CPU control unit, the GPU and the APU. Each requester issues word or byte reads and writes through a req/ack handshake. A round-robin arbiter picks one requester and a fixed-length FSM generates the SRAM strobes. The block sits between the requester modules and the SRAM pins that the RAM module drives today.

## Interface
- `WAIT`, default 2: number of cycles the OE/WE strobe stays low (1..15).
- `CLK` in 1: system clock; all logic on its rising edge.
- `RSTN` in 1: reset; synchronous, active-low.
- `req[2:0]` in 3: access request per port; 0=CPU, 1=GPU, 2=APU.
- `we[2:0]` in 3: per port; 1=write, 0=read.
- `addr0/addr1/addr2` in 16 each: word address per port.
- `wdata0/wdata1/wdata2` in 16 each: write data per port.
- `be0/be1/be2` in 2 each: byte enables per port; bit1=upper byte, bit0=lower byte.
- `ack[2:0]` out 3: one-cycle completion pulse per port.
- `rdata` out 16: read data, valid during the ack pulse, shared by all ports.
- `busy` out 1: high from SETUP through DONE.
- `grant` out 2: index of the port being served; holds its last value when idle.
- `sram_addr` out 16: SRAM address.
- `sram_dout` out 16: SRAM write data.
- `sram_din` in 16: SRAM read data.
- `sram_drive` out 1: data pin output enable.
- `sram_ce_n`, `sram_oe_n`, `sram_we_n`, `sram_ub_n`, `sram_lb_n` out 1 each: SRAM strobes, active-low.

## Operation
- FSM states and transitions:
  - IDLE → SETUP when any `req` is high.
  - SETUP → ACCESS after one cycle.
  - ACCESS → DONE after `WAIT` cycles.
  - DONE → IDLE after one cycle.
- Arbitration happens in IDLE only. It is round-robin:
  - The search starts at `last+1` mod 3, where `last` is the previous winner.
  - The first port with `req` high wins and is latched into `grant`.
  - `last` resets to 2, so CPU has first priority after reset.
  - Index 3 never occurs.
- Latching on entry to SETUP: the winner's address, write data, byte enables and `we` are registered. Later changes on that port are ignored until its ack.
- SETUP:
  - `sram_ce_n`=0.
  - `sram_addr` is valid.
  - `sram_ub_n`/`sram_lb_n` = inverted byte enables.
  - For writes, `sram_drive`=1 and `sram_dout` is valid.
- ACCESS:
  - Reads: `sram_oe_n`=0.
  - Writes: `sram_we_n`=0.
  - A 4-bit counter counts down from `WAIT`-1. The state exits when the counter reaches 0.
- Read capture: on the last ACCESS cycle, `sram_din` is registered into `rdata`. Disabled byte lanes are forced to 0.
- DONE:
  - `ack[grant]`=1 for exactly this cycle.
  - OE and WE are high.
  - CE, address, byte enables and (for writes) `sram_drive`/`sram_dout` are held, giving one cycle of hold time.
- Return to IDLE: CE goes high and `sram_drive`=0.
- `rdata` holds its value until the next read completes. Writes leave `rdata` unchanged.
- Byte enables `be`=00: the full cycle runs with both UB and LB high (no SRAM effect), ack is still issued, and a read returns 0.

## Timing
- Requester rules:
  - Hold `req`, `addr`, `wdata`, `be` and `we` stable from assertion until ack.
  - `req` may drop the cycle after ack.
  - If `req` is still high in the cycle after ack, it is treated as a new request.
- Latency, from `req` seen high in IDLE to the ack cycle: `WAIT`+2 cycles.
- Access period: `WAIT`+3 cycles (IDLE + SETUP + WAIT + DONE).
- Maximum wait for a requester with all three contending: 2 full accesses plus its own.
- Requests arriving outside IDLE wait for the next IDLE. A `req` pulse that drops before IDLE is lost, which is a protocol violation.
- Reset (`RSTN`=0 at a rising edge) takes effect that edge, mid-access included. Values after reset:
  - state=IDLE.
  - All `*_n` strobes = 1.
  - `sram_drive`=0.
  - `ack`=0, `rdata`=0, `busy`=0, `grant`=0.
  - `last`=2.
  - `sram_addr`=0, `sram_dout`=0.
  - No ack is issued for an aborted access.
- `WE` and `OE` are never low in the same cycle. `sram_drive` and `OE` are never both active.

## Test plan
- **Reset:** hold `RSTN`=0 for 3 cycles with `req`=111 → all strobes high, `ack`=000, `busy`=0. The first access after release is granted to CPU (`grant`=0).
- **Single write then read:** CPU writes 16'hBEEF to address 16'h0123 with `be`=11, using `WAIT`=2.
  - Write: `ack[0]` arrives 4 cycles after `req`; `sram_we_n` is low for exactly 2 cycles; address and data are stable from SETUP through DONE.
  - Read-back of the same address: `rdata`=16'hBEEF with `ack[0]`.
- **Byte lanes:** GPU writes 16'h12AA with `be`=01 over a memory word holding 16'h5555 → memory reads 16'h55AA. A read with `be`=10 returns 16'h5500.
- **Round-robin:** hold `req`=111 continuously, with each port re-asserting after its ack → ack order is 0,1,2,0,1,2, each `WAIT`+3 cycles apart.
- **Contention fairness:** CPU requests back-to-back while the APU holds `req` high → APU is acked no later than the second access.
- **Reset mid-access:** assert `RSTN`=0 in the first ACCESS cycle of a write → next cycle `sram_we_n`=1, `sram_ce_n`=1, `sram_drive`=0, no ack; after release the held request is served normally.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: round-robin arbiter giving three requesters (0=CPU, 1=GPU,
// 2=APU) access to one 16-bit asynchronous SRAM through a fixed-length
// IDLE -> SETUP -> ACCESS(WAIT cycles) -> DONE strobe sequence.
// Ports:
//   CLK, RSTN                  clock, synchronous active-low reset
//   req/we[2:0]                per-port request and write flag
//   addrN/wdataN/beN           per-port word address, write data, byte enables
//   ack[2:0]                   one-cycle completion pulse per port
//   rdata                      read data, valid with ack, held until next read
//   busy, grant                access in progress, index of port being served
//   sram_addr/dout/din/drive   SRAM address, write data, read data, data OE
//   sram_ce_n/oe_n/we_n/ub_n/lb_n  SRAM strobes, active-low
module sram_arbiter #(
  parameter int unsigned WAIT = 2
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [2:0]  req,
  input  logic [2:0]  we,
  input  logic [15:0] addr0,
  input  logic [15:0] addr1,
  input  logic [15:0] addr2,
  input  logic [15:0] wdata0,
  input  logic [15:0] wdata1,
  input  logic [15:0] wdata2,
  input  logic [1:0]  be0,
  input  logic [1:0]  be1,
  input  logic [1:0]  be2,
  output logic [2:0]  ack,
  output logic [15:0] rdata,
  output logic        busy,
  output logic [1:0]  grant,
  output logic [15:0] sram_addr,
  output logic [15:0] sram_dout,
  input  logic [15:0] sram_din,
  output logic        sram_drive,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam int unsigned CW = 4;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  logic [1:0]    state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [1:0]    last, last_d;
  logic [1:0]    be_q, be_d;
  logic          we_q, we_d;
  logic [1:0]    grant_d;
  logic [15:0]   addr_d, dout_d, rdata_d;
  logic [2:0]    ack_d;
  logic          busy_d, drive_d, ce_n_d, oe_n_d, we_n_d, ub_n_d, lb_n_d;
  logic [1:0]    p0, p1, p2, win;

  // Next state and next value of every registered output.
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    last_d  = last;
    be_d    = be_q;
    we_d    = we_q;
    grant_d = grant;
    addr_d  = sram_addr;
    dout_d  = sram_dout;
    rdata_d = rdata;

    // Round-robin search order starting after the previous winner.
    p0  = (last == 2'd2) ? 2'd0 : last + 2'd1;
    p1  = (p0 == 2'd2) ? 2'd0 : p0 + 2'd1;
    p2  = (p1 == 2'd2) ? 2'd0 : p1 + 2'd1;
    win = p2;
    if (req[p1]) win = p1;
    if (req[p0]) win = p0;

    unique case (state)
      S_IDLE: begin
        if (|req) begin
          state_d = S_SETUP;
          grant_d = win;
          last_d  = win;
          we_d    = we[win];
          unique case (win)
            2'd0:    begin addr_d = addr0; dout_d = wdata0; be_d = be0; end
            2'd1:    begin addr_d = addr1; dout_d = wdata1; be_d = be1; end
            default: begin addr_d = addr2; dout_d = wdata2; be_d = be2; end
          endcase
        end
      end
      S_SETUP: begin
        state_d = S_ACCESS;
        cnt_d   = CW'(WAIT - 1);
      end
      S_ACCESS: begin
        if (cnt == '0) begin
          state_d = S_DONE;
          // Disabled lanes read as zero regardless of what the pins carry.
          if (!we_q)
            rdata_d = {be_q[1] ? sram_din[15:8] : 8'h00,
                       be_q[0] ? sram_din[7:0]  : 8'h00};
        end else begin
          cnt_d = cnt - CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes follow the state being entered so they are glitch-free registers.
    busy_d  = (state_d != S_IDLE);
    ce_n_d  = (state_d == S_IDLE);
    oe_n_d  = !((state_d == S_ACCESS) && !we_d);
    we_n_d  = !((state_d == S_ACCESS) && we_d);
    drive_d = (state_d != S_IDLE) && we_d;
    ub_n_d  = (state_d == S_IDLE) || !be_d[1];
    lb_n_d  = (state_d == S_IDLE) || !be_d[0];
    ack_d   = '0;
    if (state_d == S_DONE) ack_d[grant_d] = 1'b1;
  end

  // State and output registers.
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state      <= S_IDLE;
      cnt        <= '0;
      last       <= 2'd2;
      be_q       <= '0;
      we_q       <= 1'b0;
      grant      <= '0;
      sram_addr  <= '0;
      sram_dout  <= '0;
      rdata      <= '0;
      ack        <= '0;
      busy       <= 1'b0;
      sram_drive <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_ub_n  <= 1'b1;
      sram_lb_n  <= 1'b1;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      last       <= last_d;
      be_q       <= be_d;
      we_q       <= we_d;
      grant      <= grant_d;
      sram_addr  <= addr_d;
      sram_dout  <= dout_d;
      rdata      <= rdata_d;
      ack        <= ack_d;
      busy       <= busy_d;
      sram_drive <= drive_d;
      sram_ce_n  <= ce_n_d;
      sram_oe_n  <= oe_n_d;
      sram_we_n  <= we_n_d;
      sram_ub_n  <= ub_n_d;
      sram_lb_n  <= lb_n_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter with WAIT=2 and a behavioural async SRAM model.
module tb_sram_arbiter;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [2:0]  req = '0;
  logic [2:0]  we = '0;
  logic [15:0] addr0 = '0, addr1 = '0, addr2 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0, wdata2 = '0;
  logic [1:0]  be0 = '0, be1 = '0, be2 = '0;
  logic [2:0]  ack;
  logic [15:0] rdata;
  logic        busy;
  logic [1:0]  grant;
  logic [15:0] sram_addr, sram_dout, sram_din;
  logic        sram_drive, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n;

  int tests = 0;
  int fails = 0;
  int viol  = 0;

  logic [15:0] mem [0:65535];

  sram_arbiter #(.WAIT(2)) dut (
    .CLK(CLK), .RSTN(RSTN), .req(req), .we(we),
    .addr0(addr0), .addr1(addr1), .addr2(addr2),
    .wdata0(wdata0), .wdata1(wdata1), .wdata2(wdata2),
    .be0(be0), .be1(be1), .be2(be2),
    .ack(ack), .rdata(rdata), .busy(busy), .grant(grant),
    .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
    .sram_drive(sram_drive), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
    .sram_we_n(sram_we_n), .sram_ub_n(sram_ub_n), .sram_lb_n(sram_lb_n)
  );

  always #5 CLK = ~CLK;

  // SRAM model: disabled or idle lanes float to a junk pattern.
  assign sram_din = sram_oe_n ? 16'hC3C3 :
                    {sram_ub_n ? 8'hC3 : mem[sram_addr][15:8],
                     sram_lb_n ? 8'hC3 : mem[sram_addr][7:0]};

  always @(posedge CLK) begin
    if (!sram_ce_n && !sram_we_n) begin
      if (!sram_ub_n) mem[sram_addr][15:8] <= sram_dout[15:8];
      if (!sram_lb_n) mem[sram_addr][7:0]  <= sram_dout[7:0];
    end
  end

  always @(negedge CLK) begin
    if (!sram_we_n && !sram_oe_n) viol++;
    if (sram_drive && !sram_oe_n) viol++;
  end

  task automatic set_port(input int p, input logic w, input logic [15:0] a,
                          input logic [15:0] d, input logic [1:0] b);
    we[p] = w;
    case (p)
      0: begin addr0 = a; wdata0 = d; be0 = b; end
      1: begin addr1 = a; wdata1 = d; be1 = b; end
      default: begin addr2 = a; wdata2 = d; be2 = b; end
    endcase
  endtask

  // One access on an idle arbiter; lat = -1 when no ack arrives in time.
  task automatic access(input int p, input logic w, input logic [15:0] a,
                        input logic [15:0] d, input logic [1:0] b,
                        output int lat, output logic [15:0] rd);
    @(negedge CLK);
    set_port(p, w, a, d, b);
    req[p] = 1'b1;
    lat = -1;
    rd  = 'x;
    for (int n = 1; n <= 40; n++) begin
      @(negedge CLK);
      if (ack[p]) begin lat = n; rd = rdata; break; end
    end
    req[p] = 1'b0;
  endtask

  task automatic test_reset();
    int got;
    RSTN = 1'b0;
    req  = 3'b111;
    we   = 3'b111;
    for (int p = 0; p < 3; p++) set_port(p, 1'b1, 16'h0300, 16'h0000, 2'b11);
    repeat (3) @(negedge CLK);
    tests++;
    if ({sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n} !== 5'b11111) begin
      fails++; $display("FAIL reset_strobes: got %b want 11111",
        {sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n});
    end
    tests++;
    if ({ack, busy, sram_drive, grant} !== 7'b0) begin
      fails++; $display("FAIL reset_ctrl: ack=%b busy=%b drive=%b grant=%0d want 0",
        ack, busy, sram_drive, grant);
    end
    tests++;
    if ({rdata, sram_addr, sram_dout} !== 48'h0) begin
      fails++; $display("FAIL reset_data: rdata=%h addr=%h dout=%h want 0",
        rdata, sram_addr, sram_dout);
    end
    RSTN = 1'b1;
    @(negedge CLK);
    tests++;
    if (grant !== 2'd0 || busy !== 1'b1 || sram_ce_n !== 1'b0) begin
      fails++; $display("FAIL reset_first_grant: grant=%0d busy=%b ce_n=%b want 0/1/0",
        grant, busy, sram_ce_n);
    end
    got = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      if (|ack) begin got = n; break; end
    end
    tests++;
    if (got !== 3 || ack !== 3'b001) begin
      fails++; $display("FAIL reset_first_ack: after %0d ack=%b want 3 001", got, ack);
    end
    req = '0;
    we  = '0;
  endtask

  task automatic test_write_read();
    int ack_at, we_low, lat;
    logic stable;
    logic [15:0] rd;
    @(negedge CLK);
    set_port(0, 1'b1, 16'h0123, 16'hBEEF, 2'b11);
    req[0] = 1'b1;
    ack_at = -1; we_low = 0; stable = 1'b1;
    for (int n = 1; n <= 5; n++) begin
      @(negedge CLK);
      if (!sram_we_n) we_low++;
      if (n <= 4 && (sram_addr !== 16'h0123 || sram_dout !== 16'hBEEF ||
                     sram_ce_n !== 1'b0 || sram_drive !== 1'b1 ||
                     sram_ub_n !== 1'b0 || sram_lb_n !== 1'b0)) stable = 1'b0;
      if (ack[0] && ack_at < 0) ack_at = n;
      if (n == 4) req[0] = 1'b0;
      if (n == 5) begin
        tests++;
        if (sram_ce_n !== 1'b1 || sram_drive !== 1'b0 || ack !== 3'b000 || busy !== 1'b0) begin
          fails++; $display("FAIL write_release: ce_n=%b drive=%b ack=%b busy=%b want 1/0/000/0",
            sram_ce_n, sram_drive, ack, busy);
        end
      end
    end
    tests++;
    if (ack_at !== 4) begin
      fails++; $display("FAIL write_latency: got %0d want 4", ack_at);
    end
    tests++;
    if (we_low !== 2) begin
      fails++; $display("FAIL write_we_width: got %0d want 2", we_low);
    end
    tests++;
    if (stable !== 1'b1) begin
      fails++; $display("FAIL write_hold: got %b want 1", stable);
    end
    access(0, 1'b0, 16'h0123, 16'h0000, 2'b11, lat, rd);
    tests++;
    if (rd !== 16'hBEEF || lat !== 4) begin
      fails++; $display("FAIL read_back: got %h lat %0d want beef lat 4", rd, lat);
    end
  endtask

  task automatic test_byte_lanes();
    int lat;
    logic [15:0] rd;
    access(1, 1'b1, 16'h0040, 16'h5555, 2'b11, lat, rd);
    access(1, 1'b1, 16'h0040, 16'h12AA, 2'b01, lat, rd);
    access(1, 1'b0, 16'h0040, 16'h0000, 2'b11, lat, rd);
    tests++;
    if (rd !== 16'h55AA) begin
      fails++; $display("FAIL lane_merge: got %h want 55aa", rd);
    end
    access(1, 1'b0, 16'h0040, 16'h0000, 2'b10, lat, rd);
    tests++;
    if (rd !== 16'h5500) begin
      fails++; $display("FAIL lane_upper_read: got %h want 5500", rd);
    end
    access(1, 1'b0, 16'h0040, 16'h0000, 2'b00, lat, rd);
    tests++;
    if (rd !== 16'h0000 || lat !== 4) begin
      fails++; $display("FAIL lane_none: got %h lat %0d want 0000 lat 4", rd, lat);
    end
    access(1, 1'b1, 16'h0040, 16'hFFFF, 2'b00, lat, rd);
    access(1, 1'b0, 16'h0040, 16'h0000, 2'b11, lat, rd);
    tests++;
    if (rd !== 16'h55AA) begin
      fails++; $display("FAIL lane_none_write: got %h want 55aa", rd);
    end
  endtask

  task automatic test_round_robin();
    int port_q[$];
    int time_q[$];
    logic onehot;
    @(negedge CLK);
    RSTN = 1'b0;
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;
    for (int p = 0; p < 3; p++) set_port(p, 1'b0, 16'h0123, 16'h0000, 2'b11);
    req = 3'b111;
    onehot = 1'b1;
    for (int n = 1; n <= 60 && port_q.size() < 6; n++) begin
      @(negedge CLK);
      if (|ack) begin
        if (!$onehot(ack)) onehot = 1'b0;
        for (int k = 0; k < 3; k++) if (ack[k]) port_q.push_back(k);
        time_q.push_back(n);
      end
    end
    req = '0;
    tests++;
    if (port_q.size() !== 6 || onehot !== 1'b1) begin
      fails++; $display("FAIL rr_count: got %0d onehot %b want 6 1", port_q.size(), onehot);
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests++;
        if (port_q[i] !== i % 3) begin
          fails++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, port_q[i], i % 3);
        end
        if (i > 0) begin
          tests++;
          if (time_q[i] - time_q[i-1] !== 5) begin
            fails++; $display("FAIL rr_spacing[%0d]: got %0d want 5", i, time_q[i] - time_q[i-1]);
          end
        end
      end
    end
  endtask

  task automatic test_contention();
    int port_q[$];
    logic apu_done, gpu_seen;
    @(negedge CLK);
    @(negedge CLK);
    set_port(0, 1'b0, 16'h0123, 16'h0000, 2'b11);
    set_port(2, 1'b0, 16'h0040, 16'h0000, 2'b11);
    req = 3'b101;
    apu_done = 1'b0; gpu_seen = 1'b0;
    for (int n = 1; n <= 40 && !apu_done; n++) begin
      @(negedge CLK);
      if (ack[1]) gpu_seen = 1'b1;
      if (ack[0]) port_q.push_back(0);
      if (ack[2]) begin port_q.push_back(2); apu_done = 1'b1; end
    end
    req = '0;
    tests++;
    if (apu_done !== 1'b1 || port_q.size() > 2 || gpu_seen !== 1'b0) begin
      fails++; $display("FAIL contention_apu: served %b after %0d acks gpu %b want 1 <=2 0",
        apu_done, port_q.size(), gpu_seen);
    end
    tests++;
    if (port_q.size() !== 2 || port_q[0] !== 0) begin
      fails++; $display("FAIL contention_order: got %0d acks first %0d want 2 first 0",
        port_q.size(), port_q.size() > 0 ? port_q[0] : -1);
    end
  endtask

  task automatic test_reset_mid_access();
    int lat;
    logic [15:0] rd;
    @(negedge CLK);
    set_port(0, 1'b1, 16'h0200, 16'h1234, 2'b11);
    req[0] = 1'b1;
    repeat (2) @(negedge CLK);
    tests++;
    if (sram_we_n !== 1'b0) begin
      fails++; $display("FAIL abort_in_access: we_n=%b want 0", sram_we_n);
    end
    RSTN = 1'b0;
    @(negedge CLK);
    tests++;
    if ({sram_we_n, sram_ce_n, sram_drive, ack, busy} !== 7'b1100000) begin
      fails++; $display("FAIL abort_state: we_n=%b ce_n=%b drive=%b ack=%b busy=%b want 1 1 0 000 0",
        sram_we_n, sram_ce_n, sram_drive, ack, busy);
    end
    RSTN = 1'b1;
    lat = -1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge CLK);
      if (ack[0]) begin lat = n; break; end
    end
    req[0] = 1'b0;
    tests++;
    if (lat !== 4) begin
      fails++; $display("FAIL abort_retry_latency: got %0d want 4", lat);
    end
    access(0, 1'b0, 16'h0200, 16'h0000, 2'b11, lat, rd);
    tests++;
    if (rd !== 16'h1234) begin
      fails++; $display("FAIL abort_retry_data: got %h want 1234", rd);
    end
  endtask

  task automatic test_invariants();
    tests++;
    if (viol !== 0) begin
      fails++; $display("FAIL strobe_overlap: got %0d cycles want 0", viol);
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_round_robin();
    test_contention();
    test_reset_mid_access();
    test_invariants();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
